// File: rtl/sha1_pkg.sv
// sha1_pkg: shared constants and FSM encoding for the SHA-1 streaming hasher.
package sha1_pkg;
  localparam int BLOCK_W = 512;
  localparam int DIGEST_W = 160;
  localparam logic [DIGEST_W-1:0] SHA1_IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  typedef enum logic [2:0] {FILL, HASH, PADA, PADB, OUT} state_t;
endpackage

// File: rtl/sha1_block_buf.sv
// sha1_block_buf: byte-addressed 64-byte block with beat write, pad/length insertion and clear.
module sha1_block_buf
  import sha1_pkg::*;
#(
  parameter int BEAT_BYTES = 4,
  localparam int NB_W = $clog2(BEAT_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    wr,
  input  logic [6:0]              ptr,
  input  logic [NB_W-1:0]         nb,
  input  logic [8*BEAT_BYTES-1:0] beat,
  input  logic                    pad,
  input  logic [6:0]              r,
  input  logic                    mark,
  input  logic                    add_len,
  input  logic [63:0]             bitlen,
  output logic [BLOCK_W-1:0]      blk
);
  // Padding keeps bytes below r, optionally marks byte r with 0x80, zeros the rest
  // and optionally drops the big-endian bit length into bytes 56..63.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) blk <= '0;
    else if (clr) blk <= '0;
    else if (wr) begin
      for (int i = 0; i < 64; i++)
        if (i >= int'(ptr) && i < int'(ptr) + int'(nb))
          blk[BLOCK_W-1-8*i -: 8] <= beat[8*BEAT_BYTES-1-8*(i-int'(ptr)) -: 8];
    end else if (pad) begin
      for (int i = 0; i < 64; i++)
        if (i == int'(r) && mark) blk[BLOCK_W-1-8*i -: 8] <= PAD_BYTE;
        else if (i >= int'(r)) blk[BLOCK_W-1-8*i -: 8] <= (add_len && i >= 56) ? bitlen[8*(63-i) +: 8] : 8'h00;
    end
endmodule

// File: rtl/sha1_stream_hasher.sv
// sha1_stream_hasher: streaming SHA-1 padding and chaining controller around an external sha1_update core.
// Optional SHA1_MIDSTATE_EN adds mid_load/mid_hash/mid_len to resume from a precomputed prefix.
module sha1_stream_hasher
  import sha1_pkg::*;
#(
  parameter int BEAT_BYTES = 4,
  parameter int LEN_W = 61,
  localparam int NB_W = $clog2(BEAT_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*BEAT_BYTES-1:0] in_data,
  input  logic                    in_last,
  input  logic [NB_W-1:0]         in_nbytes,
  output logic                    core_start,
  output logic [BLOCK_W-1:0]      core_data,
  output logic [DIGEST_W-1:0]     core_hash_in,
  input  logic                    core_done,
  input  logic [DIGEST_W-1:0]     core_hash_out,
  output logic                    digest_valid,
  input  logic                    digest_ready,
  output logic [DIGEST_W-1:0]     digest,
  output logic                    busy
`ifdef SHA1_MIDSTATE_EN
  ,
  input  logic                    mid_load,
  input  logic [DIGEST_W-1:0]     mid_hash,
  input  logic [LEN_W-1:0]        mid_len
`endif
);
  state_t state;
  logic [6:0] ptr, ptr_nx;
  logic [LEN_W-1:0] len, len_base;
  logic [DIGEST_W-1:0] hash, hash_ld;
  logic [NB_W-1:0] nb;
  logic [63:0] bitlen;
  logic last_seen, final_blk, need_b, mid, acc;
  assign in_ready = state == FILL;
  assign acc = in_valid && in_ready;
  assign nb = (in_nbytes > NB_W'(BEAT_BYTES)) ? NB_W'(BEAT_BYTES) : in_nbytes;
  assign ptr_nx = ptr + 7'(nb);
  assign bitlen = 64'({len, 3'b000});
  assign core_hash_in = hash;
`ifdef SHA1_MIDSTATE_EN
  assign mid = mid_load && state == FILL && ptr == '0 && len == '0;
  assign len_base = mid ? mid_len : len;
  assign hash_ld = mid_hash;
`else
  assign mid = 1'b0;
  assign len_base = len;
  assign hash_ld = SHA1_IV;
`endif
  sha1_block_buf #(.BEAT_BYTES(BEAT_BYTES)) u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == OUT && digest_ready),
    .wr(acc),
    .ptr(ptr),
    .nb(nb),
    .beat(in_data),
    .pad(state == PADA || state == PADB),
    .r(state == PADA ? ptr : 7'd0),
    .mark(state == PADA || !need_b),
    .add_len(state == PADB || ptr < 7'd56),
    .bitlen(bitlen),
    .blk(core_data)
  );
  // last_seen: message ended exactly on a block edge; need_b: a zeros+length block still follows.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= FILL;
      ptr <= '0;
      len <= '0;
      hash <= SHA1_IV;
      last_seen <= 1'b0;
      final_blk <= 1'b0;
      need_b <= 1'b0;
      core_start <= 1'b0;
      digest_valid <= 1'b0;
      digest <= '0;
      busy <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        FILL: begin
          if (mid) hash <= hash_ld;
          if (acc) begin
            ptr <= ptr_nx;
            len <= len_base + LEN_W'(nb);
            busy <= 1'b1;
            if (ptr_nx == 7'd64) begin
              core_start <= 1'b1;
              last_seen <= in_last;
              final_blk <= 1'b0;
              state <= HASH;
            end else if (in_last) state <= PADA;
          end else if (mid) len <= len_base;
        end
        HASH: if (core_done) begin
          hash <= core_hash_out;
          if (final_blk) begin
            digest <= core_hash_out;
            digest_valid <= 1'b1;
            state <= OUT;
          end else if (need_b || last_seen) state <= PADB;
          else begin
            ptr <= '0;
            state <= FILL;
          end
        end
        PADA: begin
          core_start <= 1'b1;
          final_blk <= ptr < 7'd56;
          need_b <= ptr >= 7'd56;
          state <= HASH;
        end
        PADB: begin
          core_start <= 1'b1;
          final_blk <= 1'b1;
          need_b <= 1'b0;
          last_seen <= 1'b0;
          state <= HASH;
        end
        OUT: if (digest_ready) begin
          digest_valid <= 1'b0;
          hash <= SHA1_IV;
          len <= '0;
          ptr <= '0;
          busy <= 1'b0;
          state <= FILL;
        end
        default: state <= FILL;
      endcase
    end
endmodule

// File: tb/tb_sha1_stream_hasher.sv
// tb_sha1_stream_hasher: known vectors, boundary and random messages against a queue-based SHA-1 model.
module tb_sha1_stream_hasher;
  localparam int BB = 4;
  localparam int NBW = $clog2(BB + 1);
  localparam logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0, digest_ready = 1'b0, core_done = 1'b0;
  logic [8*BB-1:0] in_data = '0;
  logic [NBW-1:0] in_nbytes = '0;
  logic [159:0] core_hash_out = '0;
  logic in_ready, core_start, digest_valid, busy;
  logic [511:0] core_data;
  logic [159:0] core_hash_in, digest;

  int compared = 0, mismatched = 0, starts = 0, min_lat = 1, epoch = 0;
  bit gaps = 1'b0, abort = 1'b0;
  logic [7:0] msg[$];

  typedef struct { string s; logic [159:0] d; int blocks; } vec_t;
  vec_t vt[3];

  sha1_stream_hasher #(.BEAT_BYTES(BB), .LEN_W(61)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes), .core_start(core_start), .core_data(core_data),
    .core_hash_in(core_hash_in), .core_done(core_done), .core_hash_out(core_hash_out),
    .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
    logic [31:0] w[80];
    logic [31:0] a, b, c, d, e, f, k, tmp;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 80; t++) begin
      tmp = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
      w[t] = {tmp[30:0], tmp[31]};
    end
    a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
    for (int t = 0; t < 80; t++) begin
      if (t < 20) begin f = (b & c) | (~b & d); k = 32'h5A827999; end
      else if (t < 40) begin f = b ^ c ^ d; k = 32'h6ED9EBA1; end
      else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else begin f = b ^ c ^ d; k = 32'hCA62C1D6; end
      tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
    end
    return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction

  function automatic void ref_model(output logic [159:0] dg, output int nblk);
    logic [7:0] p[$];
    logic [63:0] bits;
    logic [511:0] blk;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bits = 64'(msg.size()) << 3;
    for (int i = 0; i < 8; i++) p.push_back(bits[63-8*i -: 8]);
    dg = IV;
    nblk = p.size() / 64;
    for (int bk = 0; bk < nblk; bk++) begin
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = p[64*bk+i];
      dg = sha1_compress(dg, blk);
    end
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural sha1_update core with random latency.
  logic [511:0] cm_d;
  logic [159:0] cm_h;
  int cm_ep;
  initial forever begin
    @(negedge clk);
    if (rst_n && core_start) begin
      starts++;
      cm_d = core_data;
      cm_h = core_hash_in;
      cm_ep = epoch;
      repeat (min_lat + int'($urandom_range(0, 3))) @(negedge clk);
      if (cm_ep == epoch) begin
        chk("core_data stable", {352'd0, core_data[511:352]} ^ {352'd0, cm_d[511:352]}, '0);
        chk("core_hash_in stable", core_hash_in, cm_h);
      end
      core_hash_out = sha1_compress(cm_h, cm_d);
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
      core_hash_out = {5{$urandom}};
    end
  end

  task automatic set_str(input string s);
    msg.delete();
    for (int i = 0; i < s.len(); i++) msg.push_back(s[i]);
  endtask

  task automatic set_rand(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  task automatic send_msg();
    int n, nbeats, t, left, idx;
    logic rdy;
    n = msg.size();
    nbeats = (n == 0) ? 1 : (n + BB - 1) / BB;
    for (int j = 0; j < nbeats && !abort; j++) begin
      @(negedge clk);
      while (gaps && $urandom_range(0, 2) == 0) begin in_valid = 1'b0; @(negedge clk); end
      left = n - j * BB;
      for (int k = 0; k < BB; k++) begin
        idx = j * BB + k;
        in_data[8*BB-1-8*k -: 8] = (idx < n) ? msg[idx] : 8'($urandom);
      end
      in_last = (j == nbeats - 1);
      if (j == nbeats - 1) in_nbytes = NBW'(left);
      else in_nbytes = gaps ? NBW'($urandom_range(BB, (1 << NBW) - 1)) : NBW'(BB);
      in_valid = 1'b1;
      t = 0;
      forever begin
        if (abort) begin in_valid = 1'b0; break; end
        rdy = in_ready;
        @(posedge clk);
        if (rdy) break;
        @(negedge clk);
        t++;
        if (t > 3000) begin
          compared++; mismatched++;
          $display("FAIL in_ready timeout: in_ready=0 required 1");
          break;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic recv(input string nm, input logic [159:0] exp_d, input int exp_blk, input int hold);
    int t = 0;
    while (!digest_valid && t < 3000) begin @(negedge clk); t++; end
    if (!digest_valid) begin
      compared++; mismatched++;
      $display("FAIL %s timeout: digest_valid=0 required 1", nm);
      return;
    end
    chk({nm, " digest"}, digest, exp_d);
    chk({nm, " blocks"}, 160'(starts), 160'(exp_blk));
    chk({nm, " busy"}, 160'(busy), 160'd1);
    for (int h = 0; h < hold; h++) begin
      chk({nm, " hold digest"}, digest, exp_d);
      chk({nm, " hold in_ready"}, 160'(in_ready), 160'd0);
      chk({nm, " hold valid"}, 160'(digest_valid), 160'd1);
      @(negedge clk);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    if (hold > 0) begin
      chk({nm, " post in_ready"}, 160'(in_ready), 160'd1);
      chk({nm, " post valid"}, 160'(digest_valid), 160'd0);
      chk({nm, " post busy"}, 160'(busy), 160'd0);
      chk({nm, " post hash IV"}, core_hash_in, IV);
    end
  endtask

  task automatic run(input string nm, input logic [159:0] exp_d, input int exp_blk, input int hold);
    starts = 0;
    send_msg();
    recv(nm, exp_d, exp_blk, hold);
  endtask

  task automatic run_model(input string nm);
    logic [159:0] dg;
    int nb;
    ref_model(dg, nb);
    run(nm, dg, nb, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bl[13] = '{1, 4, 55, 56, 57, 63, 64, 65, 119, 120, 127, 128, 183};
    vt[0] = '{"", 160'hda39a3ee5e6b4b0d3255bfef95601890afd80709, 1};
    vt[1] = '{"abc", 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1};
    vt[2] = '{"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq",
              160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1, 2};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset in_ready", 160'(in_ready), 160'd1);
    chk("reset core_start", 160'(core_start), 160'd0);
    chk("reset digest_valid", 160'(digest_valid), 160'd0);
    chk("reset busy", 160'(busy), 160'd0);
    chk("reset core_data", {352'd0, core_data[511:352]} | {352'd0, core_data[351:192]} | {352'd0, core_data[191:32]}, '0);
    chk("reset digest", digest, '0);
    chk("reset hash", core_hash_in, IV);

    for (int i = 0; i < 3; i++) begin
      set_str(vt[i].s);
      run($sformatf("vec%0d", i), vt[i].d, vt[i].blocks, 0);
    end

    foreach (bl[i]) begin
      set_rand(bl[i]);
      run_model($sformatf("len%0d", bl[i]));
    end

    gaps = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_rand(int'($urandom_range(0, 260)));
      run_model($sformatf("rand%0d", i));
    end
    gaps = 1'b0;

    set_str("abc");
    run("hold", 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1, 10);

    // Reset while the second of three blocks is being compressed.
    set_rand(150);
    min_lat = 6;
    starts = 0;
    abort = 1'b0;
    fork send_msg(); join_none
    begin
      int t = 0;
      while (starts < 2 && t < 3000) begin @(negedge clk); t++; end
      chk("rst reached 2nd block", 160'(starts >= 2), 160'd1);
    end
    @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    epoch++;
    #1;
    chk("rst in_ready", 160'(in_ready), 160'd1);
    chk("rst busy", 160'(busy), 160'd0);
    chk("rst core_start", 160'(core_start), 160'd0);
    chk("rst hash", core_hash_in, IV);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    min_lat = 1;
    repeat (12) @(negedge clk);
    chk("stray done hash", core_hash_in, IV);
    chk("stray done busy", 160'(busy), 160'd0);
    abort = 1'b0;
    set_str("abc");
    run("rst abc", 160'ha9993e364706816aba3e25717850c26c9cd0d89d, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/sha1_stream_hasher.md
Name: sha1_stream_hasher

Overview:
- Streaming SHA-1 front end that hashes a whole message of any length. It takes a byte stream over a valid/ready interface and assembles 512-bit blocks.
- Performs FIPS 180-4 padding and length append in hardware.
- Sequences one or more sha1_update compressions, chaining the hash state between them, and returns a 160-bit digest through a valid/ready handshake.
- Replaces the software-side padding and chaining loop around sha1_update with a synthesizable, parametrised controller.

Parameters:
- BEAT_BYTES, 4, bytes per input beat; legal values 1, 2, 4, 8, 16, 32, 64 (must divide 64).
- LEN_W, 61, width of the message byte counter; bit length is {len, 3'b000}, zero-extended to 64 bits.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_data  in  8*BEAT_BYTES  message bytes; the first byte is at the MSB.
- in_last  in  1  final beat of the message.
- in_nbytes  in  $clog2(BEAT_BYTES+1)  valid bytes in the beat, MSB-aligned.
  - Must equal BEAT_BYTES when in_last=0.
  - May be 0..BEAT_BYTES when in_last=1.
- core_start  out  1  one-cycle start pulse to sha1_update.
- core_data  out  512  block; byte 0 at [511:504]; stable from core_start until core_done.
- core_hash_in  out  160  chaining state; stable from core_start until core_done.
- core_done  in  1  compression complete.
- core_hash_out  in  160  compression result; valid while core_done=1.
- digest_valid  out  1  digest available.
- digest_ready  in  1  digest consumed when digest_valid && digest_ready.
- digest  out  160  final hash.
- busy  out  1  high from the first accepted beat until the digest handshake completes.

Behaviour:
- Reset state:
  - Outputs: in_ready=1, core_start=0, digest_valid=0, busy=0; core_data, digest and the byte pointer are 0.
  - Internals: hash register = IV 67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0; len=0.
- FSM states: FILL, HASH, PADA, PADB, OUT.
- FILL:
  - in_ready=1.
  - An accepted beat writes in_nbytes bytes at byte offset ptr; ptr and len advance by in_nbytes.
  - ptr==64 after a beat: pulse core_start next cycle and go to HASH. The state records whether in_last was seen.
  - in_last with ptr<64: go to PADA.
- HASH:
  - in_ready=0; wait for core_done, then hash <= core_hash_out.
  - Next state:
    - Pending final block: PADB.
    - in_last already seen with a full block (ptr was 64): PADB, with block = 0x80, zeros, 64-bit length.
    - Otherwise: FILL, with ptr=0.
- PADA (r=ptr bytes, 0..63):
  - Write 0x80 at offset r and zero the rest of the block.
  - r<=55: place the 64-bit bit length in bytes 56..63; this is the final block.
  - r>=56: a second block of zeros plus length follows (goes to PADB).
  - core_start pulse, then wait in HASH.
- PADB: issue the prepared block; after its core_done go to OUT.
- OUT: digest=hash, digest_valid=1 the cycle after the final core_done.
  - Held stable until digest_ready.
  - On the handshake: hash<=IV, len<=0, ptr<=0, go to FILL.
- Block counts: 0 B message gives 1 block; 55 B gives 1; 56-63 B give 2; 64 B gives 2; N full blocks plus r<=55 gives N+1.
- Boundary and error rules:
  - core_done outside HASH is ignored.
  - in_valid outside FILL is not accepted.
  - A beat whose bytes would cross the 64-byte boundary cannot occur, because BEAT_BYTES divides 64.
  - in_nbytes>BEAT_BYTES is clamped to BEAT_BYTES.
  - len wraps modulo 2^LEN_W; longer messages are unsupported.
- Reset mid-operation returns everything to the reset state immediately. A late core_done is ignored; the next message starts from IV.

Optional Feature:
- SHA1_MIDSTATE_EN
- Defined:
  - Adds inputs mid_load (1), mid_hash (160) and mid_len (LEN_W).
  - mid_load in FILL while ptr==0 && len==0 loads hash<=mid_hash and len<=mid_len, which must be a multiple of 64. This resumes a precomputed prefix.
  - mid_load at any other time is ignored.
- Undefined: ports absent; every message starts from IV with len=0.

Decomposition:
- Shared package sha1_pkg holds:
  - the IV constant SHA1_IV;
  - the block width 512 and digest width 160;
  - the padding byte 8'h80;
  - the FSM state enum.
- Sub-module sha1_block_buf: byte-addressed 64-byte block buffer. It provides beat write at ptr, padding/length insertion, and clear.

Test Plan:
- Empty message (in_last, in_nbytes=0) -> one core_start; digest da39a3ee5e6b4b0d3255bfef95601890afd80709.
- "abc", BEAT_BYTES=4, single beat, nbytes=3 -> one block; digest a9993e364706816aba3e25717850c26c9cd0d89d.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> two core_start pulses; digest 84983e441c3bd26ebaae4aa1f95129e5e54670f1.
- 1,000,000 × 'a' with random in_valid gaps -> 15626 blocks; digest 34aa973cd4c4daa4f61eeb2bdbad27316534016f.
- digest_ready held low 10 cycles after digest_valid -> digest stable, in_ready=0; on release, hash resets to IV and in_ready=1.
- rst_n asserted during HASH of a 3-block message, then "abc" sent -> stray core_done ignored; digest a9993e36....
